decoder_5to32: RTL and testbench
================================

// Module: decoder_5to32
// PURPOSE
//   Registered 5-to-32 one-hot binary decoder with enable.
//   Converts 5-bit select a[4:0] into 32-bit one-hot word d; exactly bit d[a] set when enabled.
//   Used as the address/select generator in front of the 32:1 mux datapath and register-file write-select.
// PARAMETERS
//   none -- widths fixed: SEL_W=5, OUT_W=32 (from package decoder_5to32_pkg)
// PORTS
//   clk       in   1   system clock, rising-edge
//   rst       in   1   asynchronous, active-high reset
//   en        in   1   decode enable, sampled on clk rise
//   a         in   5   binary select, sampled on clk rise
//   d         out  32  registered one-hot decode of a
//   valid     out  1   registered copy of en; high when d holds a decode
//   onehot_err out 1   (only with DECODER_5TO32_ONEHOT_CHK_EN) see CONFIGURATION
// BEHAVIOUR
//   - One clock domain (clk). Reset asynchronous active-high: on rst=1, d=32'h0, valid=0, onehot_err=0 immediately, held while rst=1.
//   - Latency 1 cycle: at rising clk with en=1 -> d <= 32'h1 << a; valid <= 1.
//   - en=0 at rising clk -> d <= 32'h0, valid <= 0 (no hold of previous value).
//   - Exactly one bit set in d whenever valid=1; d==0 whenever valid=0.
//   - Full range 0..31 legal; a=0 -> d=32'h0000_0001, a=31 -> d=32'h8000_0000; no wrap/overflow case.
//   - a changing every cycle: each cycle's d reflects a sampled at the previous edge; no glitch on d (registered).
//   - X/Z on a with en=1: unspecified in silicon; simulation must not be relied upon.
//   - rst asserted mid-stream: outputs clear asynchronously; first decode appears one edge after rst deasserts with en=1.
// CONFIGURATION
//   Macro DECODER_5TO32_ONEHOT_CHK_EN:
//   - defined: adds output onehot_err; registered, 1 cycle after d, asserted when (valid=1 and d not one-hot) or (valid=0 and d!=0); reset 0.
//     Pure checker: never alters d/valid.
//   - undefined: port onehot_err and its logic absent; all other behaviour identical.
// STRUCTURE
//   - Package decoder_5to32_pkg: localparams SEL_W=5, OUT_W=32, PRE_HI_W=2, PRE_LO_W=3; typedef sel_t (logic [4:0]), onehot_t (logic [31:0]).
//   - Sub-module decoder_nto2n (parameterised N): combinational n-to-2^n one-hot predecoder.
//     Instantiated twice: 2-to-4 on a[4:3], 3-to-8 on a[2:0].
//   - Top: 4x8 AND matrix, d_next[8*i+j] = hi[i] & lo[j] & en; then output register stage with async reset.
// TESTING
//   - Reset: rst=1 with en=1, a=5'd7 -> d=32'h0, valid=0 throughout; release, next edge -> d=32'h0000_0080, valid=1.
//   - Sweep: en=1, a=0..31, one value per 15 ns step (clk period <= 15 ns) -> after each edge d == 1<<a, $countones(d)==1.
//   - Enable: a=5'd31, en toggles 1,0,1 -> d = 32'h8000_0000, 32'h0, 32'h8000_0000; valid follows 1,0,1.
//   - Back-to-back: a=3,4,5 on consecutive edges -> d=32'h8,32'h10,32'h20 one cycle later each.
//   - Async reset mid-stream: assert rst between edges while d=32'h0001_0000 -> d=0 before next edge.
//   - With DECODER_5TO32_ONEHOT_CHK_EN: full sweep -> onehot_err stays 0; force d to 32'h3 -> onehot_err=1 next cycle.

Source files
------------

// File: rtl/decoder_5to32_pkg.sv
// Shared widths, types and helpers for the registered 5-to-32 one-hot decoder.
// The select is split into a 2-bit high field and a 3-bit low field.
// Each field is predecoded separately, and the two results are combined in a
// 4x8 AND matrix.
package decoder_5to32_pkg;

    localparam int SEL_W    = 5;
    localparam int OUT_W    = 32;
    localparam int PRE_HI_W = 2;
    localparam int PRE_LO_W = 3;
    localparam int PRE_HI_N = 1 << PRE_HI_W;
    localparam int PRE_LO_N = 1 << PRE_LO_W;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [OUT_W-1:0] onehot_t;

    // True when exactly one bit of the word is set.
    function automatic logic is_onehot(input onehot_t word);
        return (word != '0) && ((word & (word - onehot_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/decoder_nto2n.sv
// Combinational N-to-2^N one-hot predecoder.
// Output bit k is high exactly when sel equals k.
module decoder_nto2n #(
    parameter int N = 2
) (
    input  logic [N-1:0]      sel,
    output logic [2**N-1:0]   dec
);

    // Compare the select against every output index.
    always_comb begin
        dec = '0;
        for (int k = 0; k < 2**N; k++) begin
            dec[k] = (sel == N'(k));
        end
    end

endmodule

// File: rtl/decoder_5to32.sv
// Registered 5-to-32 one-hot decoder with enable.
// d holds 1 << a one cycle after a rising clk edge that sees en=1.
// d is cleared when that edge sees en=0.
// Optional build macro: DECODER_5TO32_ONEHOT_CHK_EN
//   When defined, this adds the registered onehot_err output.
//   onehot_err flags a d/valid pair that breaks the one-hot rule.
//   It is a pure checker and never alters d or valid.
module decoder_5to32
    import decoder_5to32_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  sel_t    a,
    output onehot_t d,
`ifdef DECODER_5TO32_ONEHOT_CHK_EN
    output logic    onehot_err,
`endif
    output logic    valid
);

    logic [PRE_HI_N-1:0] hi;
    logic [PRE_LO_N-1:0] lo;
    onehot_t             d_next;

    decoder_nto2n #(.N(PRE_HI_W)) u_pre_hi (
        .sel (a[SEL_W-1:PRE_LO_W]),
        .dec (hi)
    );

    decoder_nto2n #(.N(PRE_LO_W)) u_pre_lo (
        .sel (a[PRE_LO_W-1:0]),
        .dec (lo)
    );

    // AND matrix: each output bit combines one high and one low predecode line, gated by enable.
    always_comb begin
        d_next = '0;
        for (int i = 0; i < PRE_HI_N; i++) begin
            for (int j = 0; j < PRE_LO_N; j++) begin
                d_next[PRE_LO_N*i + j] = hi[i] & lo[j] & en;
            end
        end
    end

    // Output register: the decode and its valid flag share one edge and are cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d     <= '0;
            valid <= 1'b0;
        end else begin
            d     <= d_next;
            valid <= en;
        end
    end

`ifdef DECODER_5TO32_ONEHOT_CHK_EN
    // Checker register: flag a multi-hot or empty word while valid, or any set bit while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            onehot_err <= 1'b0;
        end else if (valid) begin
            onehot_err <= !is_onehot(d);
        end else begin
            onehot_err <= (d != '0);
        end
    end
`endif

endmodule

// File: tb/tb_decoder_5to32.sv
// Directed self-checking bench for decoder_5to32.
// Inputs change on the falling clk edge.
// Outputs are checked 2 ns after each rising edge.
// The onehot_err checks are compiled only with DECODER_5TO32_ONEHOT_CHK_EN.
module tb_decoder_5to32;

    logic        clk;
    logic        rst;
    logic        en;
    logic [4:0]  a;
    logic [31:0] d;
    logic        valid;
`ifdef DECODER_5TO32_ONEHOT_CHK_EN
    logic        onehot_err;
`endif

    int compared   = 0;
    int mismatched = 0;

    decoder_5to32 dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .a          (a),
        .d          (d),
`ifdef DECODER_5TO32_ONEHOT_CHK_EN
        .onehot_err (onehot_err),
`endif
        .valid      (valid)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run wanders off.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive inputs on the falling edge, then wait until just after the next rising edge.
    task automatic applyStimulus(input logic en_v, input logic [4:0] a_v);
        @(negedge clk);
        en = en_v;
        a  = a_v;
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] exp_d, input logic exp_valid);
        compared++;
        assert (d === exp_d) else begin
            mismatched++;
            $error("[TB] FAIL %s d: got %h expected %h", tag, d, exp_d);
        end
        compared++;
        assert (valid === exp_valid) else begin
            mismatched++;
            $error("[TB] FAIL %s valid: got %b expected %b", tag, valid, exp_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        a   = 5'd7;

        // Reset held with an active enable: the outputs stay clear.
        @(posedge clk); #2;
        checkOutput("reset_hold1", 32'h0, 1'b0);
        @(posedge clk); #2;
        checkOutput("reset_hold2", 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;
        checkOutput("reset_release", 32'h0000_0080, 1'b1);

        // Sweep the full select range.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i));
            checkOutput("sweep", 32'h1 << i, 1'b1);
            compared++;
            assert ($countones(d) == 1) else begin
                mismatched++;
                $error("[TB] FAIL sweep_countones a=%0d: got %0d expected 1", i, $countones(d));
            end
`ifdef DECODER_5TO32_ONEHOT_CHK_EN
            compared++;
            assert (onehot_err === 1'b0) else begin
                mismatched++;
                $error("[TB] FAIL sweep_onehot_err a=%0d: got %b expected 0", i, onehot_err);
            end
`endif
        end

        // Boundary selects with hand-written words.
        applyStimulus(1'b1, 5'd0);
        checkOutput("a_min", 32'h0000_0001, 1'b1);
        applyStimulus(1'b1, 5'd31);
        checkOutput("a_max", 32'h8000_0000, 1'b1);

        // Toggle enable with a fixed select: no hold of the previous word.
        applyStimulus(1'b1, 5'd31);
        checkOutput("en_on1", 32'h8000_0000, 1'b1);
        applyStimulus(1'b0, 5'd31);
        checkOutput("en_off", 32'h0, 1'b0);
        applyStimulus(1'b1, 5'd31);
        checkOutput("en_on2", 32'h8000_0000, 1'b1);

        // Back-to-back selects on consecutive edges.
        applyStimulus(1'b1, 5'd3);
        checkOutput("b2b_3", 32'h0000_0008, 1'b1);
        applyStimulus(1'b1, 5'd4);
        checkOutput("b2b_4", 32'h0000_0010, 1'b1);
        applyStimulus(1'b1, 5'd5);
        checkOutput("b2b_5", 32'h0000_0020, 1'b1);
        applyStimulus(1'b1, 5'd10);
        checkOutput("mid_10", 32'h0000_0400, 1'b1);
        applyStimulus(1'b1, 5'd21);
        checkOutput("mid_21", 32'h0020_0000, 1'b1);

        // Asynchronous reset between edges.
        applyStimulus(1'b1, 5'd16);
        checkOutput("pre_async", 32'h0001_0000, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("async_clear", 32'h0, 1'b0);
        @(posedge clk); #2;
        checkOutput("async_hold", 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        a   = 5'd9;
        @(posedge clk); #2;
        checkOutput("after_async", 32'h0000_0200, 1'b1);

`ifdef DECODER_5TO32_ONEHOT_CHK_EN
        // Corrupt the decode word; the checker must flag it one cycle later.
        @(negedge clk);
        force dut.d = 32'h3;
        @(posedge clk); #2;
        compared++;
        assert (onehot_err === 1'b1) else begin
            mismatched++;
            $error("[TB] FAIL forced_multi_hot onehot_err: got %b expected 1", onehot_err);
        end
        release dut.d;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
